prbs_pattern_top: RTL and testbench
===================================

Name: prbs_pattern_top

Overview:
- Self-checking PRBS link block: generator + checker.
- Generator emits a 32-bit user pattern byte-serially, repeated n times, then free-running PRBS-15 bytes.
- Checker monitors the same byte stream and raises a sticky flag once n consecutive, error-free pattern repetitions are seen.
- Used as a link bring-up / loopback self-test element; prbs_out feeds the link, pattern_detected goes to status.

Parameters:
- PRBS_SEED, 15'h7FFF, LFSR value loaded on reset; must be non-zero.
- N_W, 4, width of the repetition count n.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- pattern  input  32  pattern to transmit and detect. Byte order is [31:24] first, [7:0] last. Must be held stable while rst is low.
- n  input  4  number of pattern repetitions, 0..15. Must be held stable while rst is low.
- pattern_detected  output  1  sticky flag: n consecutive pattern repetitions received.
- prbs_out  output  8  registered transmit byte, one per clock.

Behaviour:
- Reset (clk and rst as named; reset is asynchronous, active-high):
  - prbs_out=8'h00, pattern_detected=0.
  - Generator state = PATTERN, byte index=0, repetition count=0.
  - LFSR=PRBS_SEED, checker match count=0.
- Generator FSM, states PATTERN and PRBS:
  - PATTERN: on each clock, prbs_out <= pattern byte[idx], idx = 0..3 MSB-first. idx wraps 3->0 and increments the repetition count.
  - After the 4th byte of repetition n, the next state is PRBS.
  - If n==0, the first clock after reset goes directly to PRBS; no pattern bytes are emitted.
- PRBS-15 generation:
  - Polynomial x^15+x^14+1; feedback = lfsr[14]^lfsr[13], shifted in at bit 0.
  - In PRBS state, each clock advances the LFSR 8 steps combinationally.
  - prbs_out <= the 8 feedback bits produced, first-generated bit in bit 7.
  - PRBS runs until reset; the LFSR holds during PATTERN state.
- Timing example (n=3, pattern=A5A6A7A8):
  - Clock edges 1..12 after rst deasserts give prbs_out = A5,A6,A7,A8 ×3.
  - From edge 13 onward, prbs_out carries PRBS bytes.
- Checker:
  - Registered; samples prbs_out every clock and compares it to expected byte[eidx].
  - On a match: eidx advances (wrapping 3->0) and match count +1.
  - On a mismatch: count=0. eidx=1 and count=1 if the byte equals pattern[31:24]; otherwise eidx=0.
  - When the count reaches 4*n, pattern_detected <= 1 on that edge. It stays 1 until reset.
  - For n=3 this gives pattern_detected=1 at edge 13 after reset release.
  - n==0: pattern_detected never asserts.
- Count width ≥6 bits (max 60). The count saturates once the flag is set.
- Reset mid-operation clears everything immediately, asynchronously; the sequence restarts from pattern byte 0 after release.
- A PRBS stream accidentally matching the pattern may set the flag; this is acceptable because the flag is sticky.

Decomposition:
- Package prbs_pkg: PRBS_SEED default, polynomial taps, generator state enum {PATTERN, PRBS}.
- Sub-module prbs_generator (FSM + LFSR, drives prbs_out).
- Sub-module pattern_checker (drives pattern_detected).
- Top-level only wires the two sub-modules together.

Test Plan:
- pattern=A5A6A7A8, n=3, rst pulse 20 ns -> prbs_out A5,A6,A7,A8 repeated 3×. pattern_detected 0 through edge 12, 1 at edge 13, still 1 at 500 ns.
- Same pattern, n=3: bytes from edge 13 -> match the golden PRBS-15 model seeded 7FFF (8 bits/clock, MSB first). Never all-zero for 100 clocks.
- Second rst pulse after 500 ns -> outputs 0/0 asynchronously (mid-cycle). The sequence repeats identically and the flag reasserts at edge 13.
- n=0 -> prbs_out is PRBS from edge 1; pattern_detected stays 0 for 200 clocks.
- n=15, pattern=DEADBEEF -> 60 pattern bytes, then pattern_detected=1 at edge 61.
- Assert rst at edge 7 with n=3 -> flag stays 0; after release the full 12-byte sequence restarts and the flag sets 13 edges later.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS pattern generator/checker slice.
//   - PRBS_SEED_DEFAULT : LFSR reset value (must be non-zero)
//   - TAP_A / TAP_B     : feedback taps for x^15 + x^14 + 1
//   - gen_state_e       : generator FSM states
//   - prbs_advance8()   : advance the LFSR eight steps, return new state + byte
//   - pattern_byte()    : select byte idx of the 32-bit pattern, MSB first
package prbs_pkg;

  localparam logic [14:0] PRBS_SEED_DEFAULT = 15'h7FFF;
  localparam int unsigned PRBS_LEN          = 15;
  localparam int unsigned TAP_A             = 14;
  localparam int unsigned TAP_B             = 13;

  typedef enum logic {
    PATTERN = 1'b0,
    PRBS    = 1'b1
  } gen_state_e;

  typedef struct packed {
    logic [PRBS_LEN-1:0] lfsr;
    logic [7:0]          data;
  } prbs_step_t;

  // First generated feedback bit lands in data[7].
  function automatic prbs_step_t prbs_advance8(input logic [PRBS_LEN-1:0] lfsr_in);
    prbs_step_t          res;
    logic [PRBS_LEN-1:0] l;
    logic                fb;
    l   = lfsr_in;
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      fb                 = l[TAP_A] ^ l[TAP_B];
      res.data[3'(7 - i)] = fb;
      l                  = {l[PRBS_LEN-2:0], fb};
    end
    res.lfsr = l;
    return res;
  endfunction

  function automatic logic [7:0] pattern_byte(input logic [31:0] pat,
                                              input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = pat[31:24];
      2'd1:    b = pat[23:16];
      2'd2:    b = pat[15:8];
      default: b = pat[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pattern_checker.sv
// pattern_checker: watches the byte stream and raises a sticky flag once
// 4*n consecutive pattern bytes (n full repetitions) have been seen.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   pattern_i  : expected pattern, [31:24] first
//   n_i        : required repetitions (0 = never detect)
//   data_i     : monitored byte stream
//   detected_o : sticky detect flag
module pattern_checker
  import prbs_pkg::*;
#(
  parameter int unsigned N_W = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [31:0]    pattern_i,
  input  logic [N_W-1:0] n_i,
  input  logic [7:0]     data_i,
  output logic           detected_o
);

  localparam int unsigned CNT_W = N_W + 2;

  logic [1:0]       eidx_q, eidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] target;

  assign target = {n_i, 2'b00};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eidx_q <= '0;
      cnt_q  <= '0;
      det_q  <= 1'b0;
    end else begin
      eidx_q <= eidx_d;
      cnt_q  <= cnt_d;
      det_q  <= det_d;
    end
  end

  always_comb begin
    eidx_d = eidx_q;
    cnt_d  = cnt_q;
    det_d  = det_q;
    // Once detected the count freezes; the flag is sticky until reset.
    if (!det_q) begin
      if (data_i == pattern_byte(pattern_i, eidx_q)) begin
        eidx_d = eidx_q + 2'd1;
        cnt_d  = cnt_q + 1'b1;
      end else if (data_i == pattern_i[31:24]) begin
        // A mismatching byte may itself start a new repetition.
        eidx_d = 2'd1;
        cnt_d  = CNT_W'(1);
      end else begin
        eidx_d = '0;
        cnt_d  = '0;
      end
      if ((n_i != '0) && (cnt_d == target)) begin
        det_d = 1'b1;
      end
    end
  end

  assign detected_o = det_q;

endmodule

// File: rtl/prbs_generator.sv
// prbs_generator: emits the 32-bit pattern byte-serially n times, then
// free-running PRBS-15 bytes (8 LFSR steps per clock).
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   pattern_i : pattern, [31:24] sent first
//   n_i       : repetition count (0 = straight to PRBS)
//   prbs_o    : registered transmit byte
module prbs_generator
  import prbs_pkg::*;
#(
  parameter logic [14:0] PRBS_SEED = PRBS_SEED_DEFAULT,
  parameter int unsigned N_W       = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [31:0]    pattern_i,
  input  logic [N_W-1:0] n_i,
  output logic [7:0]     prbs_o
);

  gen_state_e          state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [N_W-1:0]      rep_q, rep_d;
  logic [PRBS_LEN-1:0] lfsr_q, lfsr_d;
  logic [7:0]          prbs_q, prbs_d;
  prbs_step_t          step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PATTERN;
      idx_q   <= '0;
      rep_q   <= '0;
      lfsr_q  <= PRBS_SEED;
      prbs_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      lfsr_q  <= lfsr_d;
      prbs_q  <= prbs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    lfsr_d  = lfsr_q;
    prbs_d  = prbs_q;
    step    = prbs_advance8(lfsr_q);

    unique case (state_q)
      PATTERN: begin
        if (n_i == '0) begin
          // No repetitions requested: the very first byte is already PRBS.
          state_d = PRBS;
          prbs_d  = step.data;
          lfsr_d  = step.lfsr;
        end else begin
          prbs_d = pattern_byte(pattern_i, idx_q);
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            rep_d = rep_q + 1'b1;
            if (rep_d == n_i) begin
              state_d = PRBS;
            end
          end
        end
      end
      PRBS: begin
        prbs_d = step.data;
        lfsr_d = step.lfsr;
      end
      default: state_d = PATTERN;
    endcase
  end

  assign prbs_o = prbs_q;

endmodule

// File: rtl/prbs_pattern_top.sv
// prbs_pattern_top: PRBS link self-test block; wires the generator output
// into the checker.
// Ports:
//   clk              : clock, rising edge
//   rst              : asynchronous active-high reset
//   pattern          : 32-bit pattern, [31:24] first; stable while rst low
//   n                : repetition count; stable while rst low
//   pattern_detected : sticky flag, n repetitions seen
//   prbs_out         : registered transmit byte
module prbs_pattern_top
  import prbs_pkg::*;
#(
  parameter logic [14:0] PRBS_SEED = PRBS_SEED_DEFAULT,
  parameter int unsigned N_W       = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    pattern,
  input  logic [N_W-1:0] n,
  output logic           pattern_detected,
  output logic [7:0]     prbs_out
);

  logic [7:0] tx_byte;

  prbs_generator #(
    .PRBS_SEED (PRBS_SEED),
    .N_W       (N_W)
  ) u_gen (
    .clk_i     (clk),
    .rst_i     (rst),
    .pattern_i (pattern),
    .n_i       (n),
    .prbs_o    (tx_byte)
  );

  pattern_checker #(
    .N_W (N_W)
  ) u_chk (
    .clk_i      (clk),
    .rst_i      (rst),
    .pattern_i  (pattern),
    .n_i        (n),
    .data_i     (tx_byte),
    .detected_o (pattern_detected)
  );

  assign prbs_out = tx_byte;

endmodule

// File: tb/tb_prbs_pattern_top.sv
module tb_prbs_pattern_top;

  localparam logic [14:0] SEED = 15'h7FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pattern = 32'hA5A6A7A8;
  logic [3:0]  n = 4'd3;
  logic        pattern_detected;
  logic [7:0]  prbs_out;

  always #5 clk = ~clk;

  prbs_pattern_top #(
    .PRBS_SEED (SEED),
    .N_W       (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pattern          (pattern),
    .n                (n),
    .pattern_detected (pattern_detected),
    .prbs_out         (prbs_out)
  );

  typedef struct {
    logic [7:0]  data;
    logic        det;
    int unsigned edge_no;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp, input int unsigned ed);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s edge %0d: got %h, expected %h", nm, ed, act, exp);
  endtask

  // Reference model: the PRBS bit sequence as a recurrence
  // b[t] = b[t-15] ^ b[t-14], history seeded with the seed bits (oldest first).
  bit          hist[$];
  int unsigned edge_cnt;

  function automatic void model_reset();
    hist.delete();
    for (int i = 14; i >= 0; i--) hist.push_back(SEED[i]);
    edge_cnt = 0;
  endfunction

  function automatic logic [7:0] model_prbs_byte();
    logic [7:0] b;
    bit         nb;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      nb = hist[0] ^ hist[1];
      b  = {b[6:0], nb};
      void'(hist.pop_front());
      hist.push_back(nb);
    end
    return b;
  endfunction

  // Stimulus-side expectation: one entry per clock edge after reset release.
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      exp_t        e;
      logic [31:0] p;
      int unsigned pos;
      edge_cnt++;
      p = pattern;
      if (edge_cnt <= 4 * n) begin
        pos    = (edge_cnt - 1) % 4;
        e.data = p[31 - 8*pos -: 8];
      end else begin
        e.data = model_prbs_byte();
      end
      e.det     = (n != 0) && (edge_cnt >= 4 * n + 1);
      e.edge_no = edge_cnt;
      sbq.push_back(e);
    end
  end

  // Monitor: samples on the falling edge, decoupled from stimulus.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_prbs_out", {24'h0, prbs_out}, 32'h0, 0);
      chk("reset_flag", {31'h0, pattern_detected}, 32'h0, 0);
    end else if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("prbs_out", {24'h0, prbs_out}, {24'h0, e.data}, e.edge_no);
      chk("pattern_detected", {31'h0, pattern_detected}, {31'h0, e.det}, e.edge_no);
    end
  end

  // Assert reset just after a rising edge, verify the async clear
  // mid-cycle, load new settings, release after two edges in reset.
  task automatic apply_reset(input logic [31:0] p, input logic [3:0] nn);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("async_rst_prbs_out", {24'h0, prbs_out}, 32'h0, 0);
    chk("async_rst_flag", {31'h0, pattern_detected}, 32'h0, 0);
    pattern = p;
    n       = nn;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rp;
    model_reset();
    #22;
    rst = 1'b0;
    // n=3 A5A6A7A8 well past 500 ns
    repeat (52) @(posedge clk);
    // second reset mid-operation, identical sequence
    apply_reset(32'hA5A6A7A8, 4'd3);
    repeat (40) @(posedge clk);
    // n=0: PRBS from the first edge, flag never set
    apply_reset(32'hA5A6A7A8, 4'd0);
    repeat (200) @(posedge clk);
    // n=15: 60 pattern bytes, flag at edge 61
    apply_reset(32'hDEADBEEF, 4'd15);
    repeat (80) @(posedge clk);
    // reset at edge 7 with n=3, then full restart
    apply_reset(32'hA5A6A7A8, 4'd3);
    repeat (6) @(posedge clk);
    apply_reset(32'hA5A6A7A8, 4'd3);
    repeat (40) @(posedge clk);
    // randomized patterns and repetition counts
    for (int it = 0; it < 8; it++) begin
      rp = $urandom;
      if (rp[31:24] == 8'h00) rp[31:24] = 8'h5A;
      apply_reset(rp, 4'($urandom_range(1, 15)));
      repeat (4 * int'(n) + 30) @(posedge clk);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
